// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the decoder, the pipeline registers and the
// writeback/register-file block.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // Index of the register that reads as zero when hardwiring is enabled
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Width of the committed-write counter
  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_regfile_if.sv
// Bundle of the MEM/WB inputs, the ID read ports, the debug port and the
// EX forwarding outputs of the writeback / register-file block.
interface wb_regfile_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
);

  // MEM/WB pipeline register outputs
  logic              i_mem_to_reg;
  logic              i_reg_write;
  logic [DATA_W-1:0] i_alu_result;
  logic [DATA_W-1:0] i_mem_data;
  logic [ADDR_W-1:0] i_rd;

  // ID-stage read ports
  logic [ADDR_W-1:0] i_rs1_addr;
  logic [ADDR_W-1:0] i_rs2_addr;
  logic [DATA_W-1:0] o_rs1_data;
  logic [DATA_W-1:0] o_rs2_data;

  // Debug read port (committed state only)
  logic [ADDR_W-1:0] i_dbg_addr;
  logic [DATA_W-1:0] o_dbg_data;

  // In-flight writeback for EX forwarding
  logic              o_wb_fwd_valid;
  logic [ADDR_W-1:0] o_wb_fwd_rd;
  logic [DATA_W-1:0] o_wb_fwd_data;

  // Committed-write counter
  logic [15:0]       o_wr_count;

  // The register-file block
  modport slave (
    input  i_mem_to_reg, i_reg_write, i_alu_result, i_mem_data, i_rd,
    input  i_rs1_addr, i_rs2_addr, i_dbg_addr,
    output o_rs1_data, o_rs2_data, o_dbg_data,
    output o_wb_fwd_valid, o_wb_fwd_rd, o_wb_fwd_data, o_wr_count
  );

  // The pipeline / ID side driving it
  modport master (
    output i_mem_to_reg, i_reg_write, i_alu_result, i_mem_data, i_rd,
    output i_rs1_addr, i_rs2_addr, i_dbg_addr,
    input  o_rs1_data, o_rs2_data, o_dbg_data,
    input  o_wb_fwd_valid, o_wb_fwd_rd, o_wb_fwd_data, o_wr_count
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Flop-based register array: one synchronous write port, three raw
// combinational read ports (two for ID, one for debug), async clear.
module regfile_2r1w #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  input  logic [ADDR_W-1:0] i_raddr_c,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_rdata_c
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];

  // Commit one register per cycle; reset clears the whole array at once
  // NOTE: this array is small discrete flops, so a full async clear is
  // cheap and required; a RAM macro would not allow resetting its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  assign o_rdata_c = r_regs[i_raddr_c];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU or load data, commits it to the register
// file, serves bypassed ID reads, exports the writeback for EX forwarding
// and counts committed writes.
module wb_regfile #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::REG_ADDR_W,
  parameter bit R0_ZERO = 1'b1
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_we;
  logic              w_bypass_en;
  logic [DATA_W-1:0] w_raw_rs1;
  logic [DATA_W-1:0] w_raw_rs2;
  logic [DATA_W-1:0] w_raw_dbg;
  logic [CNT_W-1:0]  r_wr_count;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return R0_ZERO && (addr == ADDR_W'(REG_ZERO));
  endfunction

  assign w_wb_data = bus.i_mem_to_reg ? bus.i_mem_data : bus.i_alu_result;

  // Writes to a hardwired r0 are dropped entirely (not stored, not counted)
  assign w_we = bus.i_reg_write && !is_zero_reg(bus.i_rd);

  // A write held off by reset never commits, so it must not be bypassed
  assign w_bypass_en = w_we && !rst;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (bus.i_rd),
    .i_wdata   (w_wb_data),
    .i_raddr_a (bus.i_rs1_addr),
    .i_raddr_b (bus.i_rs2_addr),
    .i_raddr_c (bus.i_dbg_addr),
    .o_rdata_a (w_raw_rs1),
    .o_rdata_b (w_raw_rs2),
    .o_rdata_c (w_raw_dbg)
  );

  // Read ports: r0 masking first, then same-cycle write-through, then array
  // NOTE: every output gets a default before the conditions, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.o_rs1_data = w_raw_rs1;
    bus.o_rs2_data = w_raw_rs2;
    bus.o_dbg_data = w_raw_dbg;
    if (is_zero_reg(bus.i_rs1_addr))                           bus.o_rs1_data = '0;
    else if (w_bypass_en && (bus.i_rs1_addr == bus.i_rd))      bus.o_rs1_data = w_wb_data;
    if (is_zero_reg(bus.i_rs2_addr))                           bus.o_rs2_data = '0;
    else if (w_bypass_en && (bus.i_rs2_addr == bus.i_rd))      bus.o_rs2_data = w_wb_data;
    if (is_zero_reg(bus.i_dbg_addr))                           bus.o_dbg_data = '0;
  end

  // Forwarding outputs are zeroed when no real write is in flight
  assign bus.o_wb_fwd_valid = w_we;
  assign bus.o_wb_fwd_rd    = w_we ? bus.i_rd  : '0;
  assign bus.o_wb_fwd_data  = w_we ? w_wb_data : '0;

  // Count committed writes; wraps naturally at 2^16
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_wr_count <= '0;
    else if (w_we) r_wr_count <= r_wr_count + 1'b1;
  end

  assign bus.o_wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the stimulus process computes expected
// outputs from an array model of the register file and queues them; the
// monitor process drains the queue and compares against the DUT.
module tb_wb_regfile;

  typedef enum int {S_RS1, S_RS2, S_DBG, S_FV, S_FRD, S_FDATA, S_CNT} sig_e;

  typedef struct {
    sig_e        sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst;

  wb_regfile_if bus ();

  wb_regfile #(.R0_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  event        sample_ev;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: architectural register contents and write count
  logic [15:0] m_regs [16];
  logic [15:0] m_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Expected ID read: r0 is zero, an in-flight committing write is seen
  // immediately, otherwise the committed value.
  function automatic logic [15:0] exp_read(input logic [3:0] a, input logic live_we,
                                           input logic [3:0] rd, input logic [15:0] wbv);
    if (a == 4'd0)               return 16'h0000;
    if (live_we && (a == rd))    return wbv;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] exp_dbg(input logic [3:0] a);
    return (a == 4'd0) ? 16'h0000 : m_regs[a];
  endfunction

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.sig)
          S_RS1:   act = bus.o_rs1_data;
          S_RS2:   act = bus.o_rs2_data;
          S_DBG:   act = bus.o_dbg_data;
          S_FV:    act = {15'd0, bus.o_wb_fwd_valid};
          S_FRD:   act = {12'd0, bus.o_wb_fwd_rd};
          S_FDATA: act = bus.o_wb_fwd_data;
          default: act = bus.o_wr_count;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  // One cycle of stimulus: drive between edges, queue expectations, then
  // advance the model over the following rising edge.
  task automatic step(input logic rst_v, input logic mtr, input logic rw,
                      input logic [15:0] alu, input logic [15:0] mem,
                      input logic [3:0] rd, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] ad, input string tag, input bit quiet);
    logic [15:0] wbv;
    logic        we;
    @(negedge clk);
    #1;
    rst              = rst_v;
    bus.i_mem_to_reg = mtr;
    bus.i_reg_write  = rw;
    bus.i_alu_result = alu;
    bus.i_mem_data   = mem;
    bus.i_rd         = rd;
    bus.i_rs1_addr   = a1;
    bus.i_rs2_addr   = a2;
    bus.i_dbg_addr   = ad;
    if (rst_v) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_cnt = 16'h0000;
    end
    wbv = mtr ? mem : alu;
    we  = rw && (rd != 4'd0);
    if (!quiet) begin
      exp_q.push_back('{S_RS1,   exp_read(a1, we && !rst_v, rd, wbv), $sformatf("%s.rs1[%0d]", tag, a1)});
      exp_q.push_back('{S_RS2,   exp_read(a2, we && !rst_v, rd, wbv), $sformatf("%s.rs2[%0d]", tag, a2)});
      exp_q.push_back('{S_DBG,   exp_dbg(ad),                          $sformatf("%s.dbg[%0d]", tag, ad)});
      exp_q.push_back('{S_FV,    {15'd0, we},                          $sformatf("%s.fwd_valid", tag)});
      exp_q.push_back('{S_FRD,   we ? {12'd0, rd} : 16'h0000,          $sformatf("%s.fwd_rd", tag)});
      exp_q.push_back('{S_FDATA, we ? wbv : 16'h0000,                  $sformatf("%s.fwd_data", tag)});
      exp_q.push_back('{S_CNT,   m_cnt,                                $sformatf("%s.wr_count", tag)});
      -> sample_ev;
    end
    @(posedge clk);
    if (we && !rst_v) begin
      m_regs[rd] = wbv;
      m_cnt      = m_cnt + 16'd1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rd, a1, a2;
    foreach (m_regs[i]) m_regs[i] = 16'h0000;
    m_cnt            = 16'h0000;
    rst              = 1'b1;
    bus.i_mem_to_reg = 1'b0;
    bus.i_reg_write  = 1'b0;
    bus.i_alu_result = '0;
    bus.i_mem_data   = '0;
    bus.i_rd         = '0;
    bus.i_rs1_addr   = '0;
    bus.i_rs2_addr   = '0;
    bus.i_dbg_addr   = '0;

    // Reset state, then every address on all three read ports
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 4'd1, 4'd2, 4'd3, "in_reset", 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 4'(i), 4'(15 - i), 4'(i), "reset_read", 1'b0);

    // ALU writeback with bypass, then load writeback to the same register
    step(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 4'd3, 4'd3, 4'd3, 4'd3, "alu_wr", 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 4'd3, 4'd3, 4'd5, 4'd3, "load_wr", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd3, 4'd3, 4'd3, 4'd3, "after_load", 1'b0);

    // Discarded write to r0
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 4'd0, 4'd0, 4'd0, 4'd0, "r0_wr", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd3, 4'd0, "after_r0", 1'b0);

    // Bubble: nothing written despite non-zero rd/data
    step(1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 4'd5, 4'd5, 4'd5, 4'd5, "bubble", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd5, 4'd5, 4'd5, 4'd5, "after_bubble", 1'b0);

    // Randomized traffic, read addresses biased toward the write target
    for (int n = 0; n < 300; n++) begin
      rd = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), rd, a1, a2, 4'($urandom_range(0, 15)),
           $sformatf("rand%0d", n), 1'b0);
    end

    // Advance the counter to 0xFFFE, then watch it wrap
    while (m_cnt != 16'hFFFE)
      step(1'b0, 1'b0, 1'b1, 16'($urandom), 16'h0, 4'($urandom_range(1, 15)),
           4'd0, 4'd0, 4'd0, "preload", 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h0000, 4'd2, 4'd2, 4'd1, 4'd2, "wrap_a", 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 16'hF0F0, 4'd2, 4'd2, 4'd1, 4'd2, "wrap_b", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd2, 4'd2, 4'd1, 4'd2, "wrap_c", 1'b0);

    // Asynchronous reset between edges after r7 is written
    step(1'b0, 1'b0, 1'b1, 16'h5A5A, 16'h0000, 4'd7, 4'd7, 4'd7, 4'd7, "r7_wr", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd7, 4'd7, 4'd7, 4'd7, "r7_held", 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd7, 4'd7, 4'd7, 4'd7, "rst_async", 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4444, 16'h0000, 4'd4, 4'd4, 4'd7, 4'd4, "rst_write", 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 4'd9, 4'd9, 4'd4, 4'd9, "rst_release", 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd9, 4'd9, 4'd4, 4'd9, "after_release", 1'b0);

    repeat (2) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the 16-bit CPU. Consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result or load data), commits it to a 16×16-bit register file, and serves two combinational read ports to ID with same-cycle write-through bypass. Also exports the in-flight writeback for EX forwarding and a committed-write counter for debug and performance monitoring.

## Interface
- DATA_W, 16, register and datapath width
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W
- R0_ZERO, 1, when 1, r0 is hardwired to zero and writes to it are discarded
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_to_reg  in  1  from MEM/WB; 1 selects mem_data, 0 selects alu_result
- reg_write  in  1  from MEM/WB; writeback enable
- alu_result  in  DATA_W  from MEM/WB
- mem_data  in  DATA_W  from MEM/WB
- rd  in  ADDR_W  from MEM/WB; destination register
- rs1_addr, rs2_addr  in  ADDR_W  ID-stage read addresses
- rs1_data, rs2_data  out  DATA_W  read data, combinational, bypassed
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, combinational, not bypassed (shows committed state)
- wb_fwd_valid  out  1  a real write is in WB this cycle
- wb_fwd_rd  out  ADDR_W  destination of that write
- wb_fwd_data  out  DATA_W  value of that write
- wr_count  out  16  number of committed register writes

## Operation
- wb_data = mem_to_reg ? mem_data : alu_result.
- Effective write: we = reg_write && !(R0_ZERO && rd == 0).
- On rising clk with we: regs[rd] <= wb_data; wr_count <= wr_count + 1.
- Without we: register array and wr_count hold. A bubble (reg_write=0 after a flush) writes nothing, regardless of rd or data values.
- Read port n (n = 1, 2): if R0_ZERO and rsn_addr==0, return 0. Else if we and rsn_addr==rd, return wb_data (write-through). Else return regs[rsn_addr].
- dbg_data = regs[dbg_addr]; r0 returns 0 when R0_ZERO.
- wb_fwd_valid = we; wb_fwd_rd = we ? rd : 0; wb_fwd_data = we ? wb_data : 0. These outputs are combinational and are zeroed when invalid so EX never matches a stale value.
- wr_count is modulo 2^16: 0xFFFF + 1 wraps to 0x0000. Discarded r0 writes are not counted.
- If R0_ZERO=0, r0 is an ordinary register.

## Timing
- Write latency: a value on the WB inputs during cycle N is in regs at the cycle N rising edge. It is visible on the rs ports in cycle N via bypass and in cycle N+1 from the array.
- Read ports and forwarding outputs are combinational, with zero-cycle latency.
- Reset: asserting rst clears all regs to 0 and wr_count to 0 immediately, independent of clk. During rst all read outputs therefore return 0, and the forwarding outputs follow the inputs combinationally.
- A write arriving in the same edge that rst deasserts commits normally. While rst is high, no write commits.
- Both read ports hitting the same address, or both hitting rd, is legal; each port returns the identical value.

## Structure
- Shared package cpu_pkg: DATA_W, REG_ADDR_W, NUM_REGS, REG_ZERO index constant. It is shared with the decoder and the pipeline registers.
- Sub-module regfile_2r1w holds the array, async reset, and raw reads. wb_regfile wraps it with the writeback mux, r0 masking, bypass, forwarding outputs, and counter.

## Test plan
- Reset, then read all 16 addresses via rs1, rs2 and dbg → all 0x0000; wr_count=0.
- reg_write=1, mem_to_reg=0, alu_result=0x1234, rd=3, rs1_addr=3 in the same cycle → rs1_data=0x1234 that cycle and dbg_data(3)=0x1234 the next cycle. With reg_write=1, mem_to_reg=1, mem_data=0xBEEF, rd=3 on the following cycle → wb_fwd_valid=1, wb_fwd_rd=3, wb_fwd_data=0xBEEF; rs1_data=0xBEEF that cycle and the register holds 0xBEEF afterwards; wr_count=2.
- Write 0xFFFF to rd=0 with R0_ZERO=1 → rs1_data(0)=0, wb_fwd_valid=0, wr_count unchanged.
- Bubble: reg_write=0, rd=5, alu_result=0xAAAA → r5 unchanged and wb_fwd_* all zero.
- Preload wr_count to 0xFFFE via 0xFFFE writes (or a forced value), then apply 2 writes → 0xFFFF, then 0x0000.
- Assert rst asynchronously mid-stream, between edges, after r7=0x5A5A → r7 and wr_count read 0 before the next edge. A write presented on the same edge that rst deasserts commits.
